seq_sort_rx: RTL

- Sequential counterpart of the team's parallel combinational min/max sorter.
- Accepts four 4-bit operands serially over a valid-qualified input stream and runs the same bitwise/adder network on them.
- Returns the two 5-bit results serially, min first then max, on a valid-qualified output stream.
- Sits between a serial nibble source and a downstream consumer that cannot present four operands in parallel.

---
 rtl/seq_sort_rx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seq_sort_rx.sv
// Serial min/max sorter: collects four WIDTH-bit operands from a valid-qualified
// stream, runs the xnor/or/and/xor adder network, and returns min then max serially.
module seq_sort_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_num,
  output logic             out_valid,
  output logic [WIDTH:0]   out_num,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CALC    = 3'd2,
    OUT_MIN = 3'd3,
    OUT_MAX = 3'd4
  } state_e;

  state_e                  state_q;
  logic [1:0]              cnt_q;
  logic [3:0][WIDTH-1:0]   a_q;
  logic [WIDTH:0]          s1_q;
  logic [WIDTH:0]          s2_q;
  logic                    out_valid_q;
  logic [WIDTH:0]          out_num_q;
  logic                    busy_q;
  logic                    err_q;

  logic [WIDTH:0]          s1_d;
  logic [WIDTH:0]          s2_d;
  logic [WIDTH:0]          min_d;
  logic [WIDTH:0]          max_d;

  // Adder network on the captured operands; min is taken straight from the sums so
  // it can be registered on the CALC edge and appear in the following cycle.
  always_comb begin
    s1_d  = {1'b0, ~(a_q[0] ^ a_q[1])} + {1'b0, (a_q[1] | a_q[3])};
    s2_d  = {1'b0, (a_q[0] & a_q[2])} + {1'b0, (a_q[2] ^ a_q[3])};
    min_d = (s1_d < s2_d) ? s1_d : s2_d;
    max_d = (s1_q < s2_q) ? s2_q : s1_q;
  end

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      a_q         <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          out_num_q   <= '0;
          if (in_valid) begin
            a_q[0]  <= in_num;
            cnt_q   <= 2'd1;
            busy_q  <= 1'b1;
            state_q <= COLLECT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            a_q[cnt_q] <= in_num;
            cnt_q      <= cnt_q + 2'd1;
            busy_q     <= 1'b1;
            if (cnt_q == 2'd3) begin
              state_q <= CALC;
            end else begin
              state_q <= COLLECT;
            end
          end else begin
            // A gap inside a frame aborts it: drop everything captured so far.
            a_q     <= '0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        CALC: begin
          s1_q        <= s1_d;
          s2_q        <= s2_d;
          out_valid_q <= 1'b1;
          out_num_q   <= min_d;
          busy_q      <= 1'b1;
          state_q     <= OUT_MIN;
        end
        OUT_MIN: begin
          out_valid_q <= 1'b1;
          out_num_q   <= max_d;
          busy_q      <= 1'b1;
          state_q     <= OUT_MAX;
        end
        OUT_MAX: begin
          out_valid_q <= 1'b0;
          out_num_q   <= '0;
          busy_q      <= 1'b0;
          cnt_q       <= 2'd0;
          a_q         <= '0;
          s1_q        <= '0;
          s2_q        <= '0;
          state_q     <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= 2'd0;
          a_q         <= '0;
          out_valid_q <= 1'b0;
          out_num_q   <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
